// File: rtl/vga_timing_generator.sv
// VGA timing generator: free-running column/row counters with registered sync and enable decodes.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync one clock to line up with registered colour data.
module vga_timing_generator #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter logic        SYNC_ACTIVE = 1'b0,
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
    localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1
) (
    input  logic          vga_clock_i,
    input  logic          reset_ni,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          display_enable_o,
    output logic [HW-1:0] column_o,
    output logic [VW-1:0] row_o,
    output logic          frame_start_o
);

    logic [HW-1:0] column_q, column_d;
    logic [VW-1:0] row_q, row_d;
    logic          de_q, de_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          fs_q, fs_d;
    logic [31:0]   col_ext, row_ext;

    // Decodes use the next counter values so every registered output describes the same pixel.
    always_comb begin
        column_d = column_q + HW'(1);
        row_d    = row_q;
        if (column_q == HW'(H_TOTAL - 1)) begin
            column_d = '0;
            row_d    = (row_q == VW'(V_TOTAL - 1)) ? '0 : row_q + VW'(1);
        end
        col_ext = 32'(column_d);
        row_ext = 32'(row_d);
        de_d    = (col_ext < H_VISIBLE) && (row_ext < V_VISIBLE);
        hsync_d = ((col_ext >= H_VISIBLE + H_FRONT) && (col_ext < H_VISIBLE + H_FRONT + H_SYNC))
                  ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = ((row_ext >= V_VISIBLE + V_FRONT) && (row_ext < V_VISIBLE + V_FRONT + V_SYNC))
                  ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        fs_d    = (column_d == '0) && (row_d == '0);
    end

    // Reset parks on the last pixel so the first clock after release lands on (0,0).
    always_ff @(posedge vga_clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            column_q <= HW'(H_TOTAL - 1);
            row_q    <= VW'(V_TOTAL - 1);
            de_q     <= 1'b0;
            hsync_q  <= ~SYNC_ACTIVE;
            vsync_q  <= ~SYNC_ACTIVE;
            fs_q     <= 1'b0;
        end else begin
            column_q <= column_d;
            row_q    <= row_d;
            de_q     <= de_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            fs_q     <= fs_d;
        end
    end

    assign column_o         = column_q;
    assign row_o            = row_q;
    assign display_enable_o = de_q;
    assign frame_start_o    = fs_q;

`ifdef VGA_SYNC_DELAY_EN
    logic hsync_dly_q, vsync_dly_q;

    always_ff @(posedge vga_clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hsync_dly_q <= ~SYNC_ACTIVE;
            vsync_dly_q <= ~SYNC_ACTIVE;
        end else begin
            hsync_dly_q <= hsync_q;
            vsync_dly_q <= vsync_q;
        end
    end

    assign hsync_o = hsync_dly_q;
    assign vsync_o = vsync_dly_q;
`else
    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: default 640x480 timing over the first line plus a miniature 8x6 timing
// over whole frames and a reset asserted inside both sync pulses.
module tb_vga_timing_generator;

`ifdef VGA_SYNC_DELAY_EN
    localparam int Dly = 1;
`else
    localparam int Dly = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rst_mini_n;
    logic       hs, vs, de, fs;
    logic [9:0] col, row;
    logic       m_hs, m_vs, m_de, m_fs;
    logic [2:0] m_col, m_row;

    int n_checks = 0;
    int n_pass   = 0;

    vga_timing_generator dut (
        .vga_clock_i      (clk),
        .reset_ni         (rst_n),
        .hsync_o          (hs),
        .vsync_o          (vs),
        .display_enable_o (de),
        .column_o         (col),
        .row_o            (row),
        .frame_start_o    (fs)
    );

    vga_timing_generator #(
        .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_VISIBLE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
    ) dut_mini (
        .vga_clock_i      (clk),
        .reset_ni         (rst_mini_n),
        .hsync_o          (m_hs),
        .vsync_o          (m_vs),
        .display_enable_o (m_de),
        .column_o         (m_col),
        .row_o            (m_row),
        .frame_start_o    (m_fs)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int de_cnt, hs_cnt, hs_first, hs_last, de_fall, vs_cnt, fs_cnt, seq_err;
        int fs_first, fs_second, vs_first, de_err;
        bit found;

        rst_n      = 1'b0;
        rst_mini_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_col", int'(col), 799);
        check("rst_row", int'(row), 524);
        check("rst_de", int'(de), 0);
        check("rst_hs", int'(hs), 1);
        check("rst_vs", int'(vs), 1);
        check("rst_fs", int'(fs), 0);
        check("rst_mini_col", int'(m_col), 7);
        check("rst_mini_row", int'(m_row), 5);

        rst_n      = 1'b1;
        rst_mini_n = 1'b1;
        @(negedge clk);
        check("first_col", int'(col), 0);
        check("first_row", int'(row), 0);
        check("first_de", int'(de), 1);
        check("first_fs", int'(fs), 1);
        check("first_hs", int'(hs), 1);
        check("first_mini_col", int'(m_col), 0);
        check("first_mini_fs", int'(m_fs), 1);

        // One full line of the default timing.
        de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; de_fall = -1;
        vs_cnt = 0; fs_cnt = 0; seq_err = 0;
        for (int i = 0; i < 800; i++) begin
            if (int'(col) != i || row != 10'd0) seq_err++;
            if (de) de_cnt++;
            else if (de_fall < 0) de_fall = int'(col);
            if (!hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(col);
                hs_last = int'(col);
            end
            if (!vs) vs_cnt++;
            if (fs) fs_cnt++;
            @(negedge clk);
        end
        check("line_seq_err", seq_err, 0);
        check("line_de_cnt", de_cnt, 640);
        check("line_de_fall_col", de_fall, 640);
        check("line_hs_cnt", hs_cnt, 96);
        check("line_hs_first", hs_first, 656 + Dly);
        check("line_hs_last", hs_last, 751 + Dly);
        check("line_vs_cnt", vs_cnt, 0);
        check("line_fs_cnt", fs_cnt, 1);
        check("wrap_col", int'(col), 0);
        check("wrap_row", int'(row), 1);
        check("wrap_fs", int'(fs), 0);
        check("wrap_de", int'(de), 1);

        // Two frames of the miniature timing from a fresh reset.
        rst_mini_n = 1'b0;
        @(negedge clk);
        rst_mini_n = 1'b1;
        @(negedge clk);
        de_cnt = 0; hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_first = -1;
        fs_cnt = 0; fs_first = -1; fs_second = -1; seq_err = 0; de_err = 0;
        for (int i = 0; i < 96; i++) begin
            if (int'(m_col) != i % 8 || int'(m_row) != (i / 8) % 6) seq_err++;
            if (m_de != ((i % 8 < 4) && ((i / 8) % 6 < 3))) de_err++;
            if (m_de) de_cnt++;
            if (!m_hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
            end
            if (!m_vs) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = i;
            end
            if (m_fs) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i;
                else if (fs_second < 0) fs_second = i;
            end
            @(negedge clk);
        end
        check("mini_seq_err", seq_err, 0);
        check("mini_de_err", de_err, 0);
        check("mini_de_cnt", de_cnt, 24);
        check("mini_hs_cnt", hs_cnt, 24);
        check("mini_hs_first", hs_first, 5 + Dly);
        check("mini_vs_cnt", vs_cnt, 16);
        check("mini_vs_first", vs_first, 32 + Dly);
        check("mini_fs_cnt", fs_cnt, 2);
        check("mini_frame_period", fs_second - fs_first, 48);

        // Reset asserted between clock edges while both sync pulses are active.
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (m_row == 3'd4 && m_col == 3'd6) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mid_found", int'(found), 1);
        check("mid_hs_low", int'(m_hs), 0);
        check("mid_vs_low", int'(m_vs), 0);
        #2 rst_mini_n = 1'b0;
        #1;
        check("async_hs", int'(m_hs), 1);
        check("async_vs", int'(m_vs), 1);
        check("async_col", int'(m_col), 7);
        check("async_row", int'(m_row), 5);
        @(negedge clk);
        rst_mini_n = 1'b1;
        @(negedge clk);
        check("restart_col", int'(m_col), 0);
        check("restart_row", int'(m_row), 0);
        check("restart_fs", int'(m_fs), 1);
        check("restart_de", int'(m_de), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
